// File: rtl/capture_sequencer.sv
// Acquisition sequencer: writes qualified samples into a circular RAM, records the trigger
// address and counts post-trigger samples. Optional pre-trigger fill: PRETRIGGER_FILL_EN.
module capture_sequencer #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    sampleTransistion,
    input  logic [SAMPLE_WIDTH-1:0] sampleData,
    input  logic                    triggerDetected,
    input  logic [ADDR_WIDTH-1:0]   postTriggerCount,
    output logic                    memWriteEn,
    output logic [ADDR_WIDTH-1:0]   memWriteAddr,
    output logic [SAMPLE_WIDTH-1:0] memWriteData,
    output logic [ADDR_WIDTH-1:0]   triggerAddr,
    output logic                    idle,
    output logic                    running,
    output logic                    triggered,
    output logic                    complete,
    output logic                    done
);

    typedef enum logic [2:0] {StIdle, StPre, StArmed, StPost, StDone} seqState_t;

    seqState_t             state;
    seqState_t             stateD;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] postCnt;
    logic [ADDR_WIDTH-1:0] postCntNext;
    logic                  accepted;
    logic                  preDone;

`ifdef PRETRIGGER_FILL_EN
    logic [ADDR_WIDTH:0] preCount;
    logic [ADDR_WIDTH:0] preCountNext;
    logic [ADDR_WIDTH:0] fillThresh;

    // Leave room for the trigger sample and all post-trigger samples.
    always_comb begin
        preCountNext = preCount + {{ADDR_WIDTH{1'b0}}, accepted};
        fillThresh   = {1'b0, {ADDR_WIDTH{1'b1}}} - {1'b0, postTriggerCount};
        preDone      = (preCountNext >= fillThresh);
    end
`else
    assign preDone = 1'b1;
`endif

    assign accepted    = sampleTransistion &&
                         ((state == StPre) || (state == StArmed) || (state == StPost));
    assign postCntNext = postCnt + 1'b1;

    always_comb begin
        stateD = state;
        if (abort && (state != StIdle)) begin
            stateD = StIdle;
        end else begin
            unique case (state)
                StIdle:  if (start) stateD = StPre;
                StPre:   if (preDone) stateD = StArmed;
                StArmed: begin
                    if (accepted && triggerDetected) begin
                        stateD = (postTriggerCount == '0) ? StDone : StPost;
                    end
                end
                StPost:  if (accepted && (postCntNext == postTriggerCount)) stateD = StDone;
                StDone:  if (!start) stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            wrPtr        <= '0;
            postCnt      <= '0;
            memWriteEn   <= 1'b0;
            memWriteAddr <= '0;
            memWriteData <= '0;
            triggerAddr  <= '0;
            idle         <= 1'b1;
            running      <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            complete     <= 1'b0;
`ifdef PRETRIGGER_FILL_EN
            preCount     <= '0;
`endif
        end else begin
            state      <= stateD;
            idle       <= (stateD == StIdle);
            running    <= (stateD == StPre) || (stateD == StArmed) || (stateD == StPost);
            triggered  <= (stateD == StPost) || (stateD == StDone);
            done       <= (stateD == StDone);
            complete   <= (stateD == StDone) && (state != StDone);
            memWriteEn <= 1'b0;

            if (!abort || (state == StIdle)) begin
                if (accepted) begin
                    memWriteEn   <= 1'b1;
                    memWriteAddr <= wrPtr;
                    memWriteData <= sampleData;
                    wrPtr        <= wrPtr + 1'b1;
                end
                if ((state == StIdle) && start) begin
                    wrPtr    <= '0;
                    postCnt  <= '0;
`ifdef PRETRIGGER_FILL_EN
                    preCount <= '0;
`endif
                end
`ifdef PRETRIGGER_FILL_EN
                if (state == StPre) preCount <= preCountNext;
`endif
                if ((state == StArmed) && accepted && triggerDetected) triggerAddr <= wrPtr;
                if ((state == StPost) && accepted) postCnt <= postCntNext;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer (ADDR_WIDTH=4); expected RAM writes are queued by
// the stimulus and popped by an independent write monitor.
module tb_capture_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sampleTransistion = 1'b0;
    logic [7:0] sampleData = '0;
    logic       triggerDetected = 1'b0;
    logic [3:0] postTriggerCount = '0;
    logic       memWriteEn;
    logic [3:0] memWriteAddr;
    logic [7:0] memWriteData;
    logic [3:0] triggerAddr;
    logic       idle, running, triggered, complete, done;

    int         vectors = 0;
    int         miscompares = 0;
    int         completeCount = 0;
    logic [11:0] expQ[$];

    capture_sequencer #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sampleTransistion(sampleTransistion), .sampleData(sampleData),
        .triggerDetected(triggerDetected), .postTriggerCount(postTriggerCount),
        .memWriteEn(memWriteEn), .memWriteAddr(memWriteAddr), .memWriteData(memWriteData),
        .triggerAddr(triggerAddr), .idle(idle), .running(running), .triggered(triggered),
        .complete(complete), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Write monitor: every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (complete) completeCount++;
        if (memWriteEn) begin
            if (expQ.size() == 0) begin
                check("unexpectedWrite", {20'h0, memWriteAddr, memWriteData}, 32'hffff_ffff);
            end else begin
                check("memWrite", {20'h0, memWriteAddr, memWriteData}, {20'h0, expQ.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendSample(input logic [7:0] d, input logic trig, input logic expWrite,
                              input logic [3:0] a);
        sampleTransistion = 1'b1;
        sampleData        = d;
        triggerDetected   = trig;
        if (expWrite) expQ.push_back({a, d});
        tick();
        sampleTransistion = 1'b0;
        triggerDetected   = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, ".memWriteEn"}, {31'h0, memWriteEn}, 32'h0);
        check({tag, ".memWriteAddr"}, {28'h0, memWriteAddr}, 32'h0);
        check({tag, ".memWriteData"}, {24'h0, memWriteData}, 32'h0);
        check({tag, ".triggerAddr"}, {28'h0, triggerAddr}, 32'h0);
        check({tag, ".status"}, {27'h0, idle, running, triggered, done, complete}, 32'h10);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        checkResetState("reset");

`ifndef PRETRIGGER_FILL_EN
        // Trigger on 5th sample, three post-trigger samples.
        postTriggerCount = 4'd3;
        start = 1'b1;
        tick();
        check("t2.running", {31'h0, running}, 32'h1);
        for (int i = 0; i < 4; i++) sendSample(8'h10 + 8'(i), 1'b0, 1'b1, 4'(i));
        sendSample(8'h14, 1'b1, 1'b1, 4'd4);
        check("t2.triggerAddr", {28'h0, triggerAddr}, 32'h4);
        check("t2.triggered", {31'h0, triggered}, 32'h1);
        for (int i = 5; i < 8; i++) sendSample(8'h10 + 8'(i), 1'b0, 1'b1, 4'(i));
        check("t2.doneComplete", {30'h0, done, complete}, 32'h3);
        tick();
        check("t2.holdDone", {30'h0, done, complete}, 32'h2);
        start = 1'b0;
        tick();
        check("t2.backIdle", {31'h0, idle}, 32'h1);

        // postTriggerCount=0; a trigger in PRE is ignored.
        postTriggerCount = 4'd0;
        start = 1'b1;
        tick();
        sendSample(8'h11, 1'b1, 1'b1, 4'd0);
        check("t3.preTrigIgnored", {31'h0, triggered}, 32'h0);
        sendSample(8'hA5, 1'b1, 1'b1, 4'd1);
        check("t3.doneComplete", {30'h0, done, complete}, 32'h3);
        check("t3.triggerAddr", {28'h0, triggerAddr}, 32'h1);
        sendSample(8'h77, 1'b0, 1'b0, 4'd0);
        check("t3.noPulse", {31'h0, complete}, 32'h0);
        start = 1'b0;
        tick();

        // 20 samples before the trigger wrap the write pointer.
        postTriggerCount = 4'd2;
        start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) sendSample(8'h20 + 8'(i), 1'b0, 1'b1, 4'(i % 16));
        sendSample(8'h40, 1'b1, 1'b1, 4'd4);
        check("t4.triggerAddr", {28'h0, triggerAddr}, 32'h4);
        sendSample(8'h41, 1'b0, 1'b1, 4'd5);
        sendSample(8'h42, 1'b0, 1'b1, 4'd6);
        check("t4.done", {31'h0, done}, 32'h1);
        start = 1'b0;
        tick();

        // Abort in ARMED after 6 samples.
        postTriggerCount = 4'd3;
        start = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) sendSample(8'h50 + 8'(i), 1'b0, 1'b1, 4'(i));
        abort = 1'b1;
        start = 1'b0;
        sendSample(8'h99, 1'b1, 1'b0, 4'd0);
        abort = 1'b0;
        check("t5.status", {27'h0, idle, running, triggered, done, complete}, 32'h10);
        check("t5.triggerKept", {28'h0, triggerAddr}, 32'h4);
        start = 1'b1;
        tick();
        sendSample(8'h61, 1'b0, 1'b1, 4'd0);
        sendSample(8'h62, 1'b1, 1'b1, 4'd1);
        check("t1.triggerAddr", {28'h0, triggerAddr}, 32'h1);
        sendSample(8'h63, 1'b0, 1'b1, 4'd2);

        // Reset in the middle of POST.
        reset = 1'b1;
        start = 1'b0;
        sendSample(8'h64, 1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        checkResetState("t1");
        tick();
        #5;
        check("completeCount", completeCount, 32'd3);
`else
        // Fill mode: threshold 16-1-5 = 10 samples in PRE.
        postTriggerCount = 4'd5;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) sendSample(8'h80 + 8'(i), 1'b1, 1'b1, 4'(i));
        check("t6.notTriggered", {30'h0, running, triggered}, 32'h2);
        sendSample(8'h8A, 1'b1, 1'b1, 4'd10);
        check("t6.triggered", {31'h0, triggered}, 32'h1);
        check("t6.triggerAddr", {28'h0, triggerAddr}, 32'd10);
        for (int i = 11; i < 16; i++) sendSample(8'h80 + 8'(i), 1'b0, 1'b1, 4'(i));
        check("t6.doneComplete", {30'h0, done, complete}, 32'h3);
        start = 1'b0;
        tick();
        check("t6.idle", {31'h0, idle}, 32'h1);
        #5;
        check("completeCount", completeCount, 32'd1);
`endif
        check("queueEmpty", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
